// File: rtl/flipflop_countdown_4b.sv
// rtl/flipflop_countdown_4b.sv - loadable prescaled down-counter with reload register and IDLE/RUN/HOLD control
// Optional periodic mode: define FLIPFLOP_COUNTDOWN_AUTO_RELOAD_EN.
module flipflop_countdown_4b #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] reload_reg,
    output logic             busy,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;
    logic [WIDTH-1:0] count_eff;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        done_d    = 1'b0;
        count_eff = count_q;

        case (state_q)
            IDLE, HOLD: begin
                if (load_valid && load_ready_q) begin
                    reload_d  = load_value;
                    count_d   = load_value;
                    count_eff = load_value;
                    state_d   = IDLE;
                end
                // start is judged against the value after any same-cycle load
                if (start && !stop && (count_eff != '0)) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    if (count_q == WIDTH'(1)) begin
                        done_d = 1'b1;
`ifdef FLIPFLOP_COUNTDOWN_AUTO_RELOAD_EN
                        count_d = reload_q;
`else
                        count_d = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d == RUN);
        load_ready_d = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            reload_q     <= '0;
            presc_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            presc_q      <= presc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign count      = count_q;
    assign reload_reg = reload_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule

// File: doc/flipflop_countdown_4b.md
# flipflop_countdown_4b

Loadable down-counter with a reload register and a start/stop control FSM: the inverse of the up-counter-with-storage block. A value is written into the storage register and then counted down to zero at a prescaled rate, with a single-cycle `done` pulse at zero. It sits beside the existing divider, counter and storage flip-flop blocks as the timer/terminal-count element of the design.

## Interface
- `WIDTH`, 4, width of the count and the reload register.
- `PRESCALE`, 2, number of `clk` cycles per decrement; legal range ≥1 (1 = decrement every cycle).

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `load_valid`  input  1  load request; qualified by `load_ready`.
- `load_ready`  output  1  load can be accepted this cycle.
- `load_value`  input  WIDTH  value to store and count from.
- `start`  input  1  begin or resume counting.
- `stop`  input  1  pause counting.
- `count`  output  WIDTH  current count value.
- `reload_reg`  output  WIDTH  last accepted load value.
- `busy`  output  1  high while counting (state RUN).
- `done`  output  1  one-cycle pulse when the count reaches zero.

## Operation
- Reset state: state IDLE, `count`=0, `reload_reg`=0, prescaler=0, `busy`=0, `done`=0, `load_ready`=1.
- FSM states:
  - IDLE: not counting, count=0 or loaded.
  - RUN: counting.
  - HOLD: paused, count frozen.
- `load_ready` = 1 in IDLE and HOLD, 0 in RUN.
- Load handshake: `load_valid && load_ready` at an edge → `reload_reg`←`load_value`, `count`←`load_value`. A load in HOLD also returns the state to IDLE.
- `start` in IDLE/HOLD with resulting count ≠0 → RUN, prescaler←0.
- `start` with count = 0 (after any same-cycle load) is ignored; the state stays as it was.
- Load and start in the same cycle: the load is applied and the start is evaluated against the loaded value.
- In RUN, the prescaler increments each cycle. At prescaler = `PRESCALE`-1 (a tick), the prescaler wraps to 0 and `count` decrements by 1.
- Terminal count: a tick with `count`=1:
  - `count`←0, `done`←1 for exactly one cycle.
  - State → IDLE, `busy`←0.
- `stop` in RUN → HOLD. Count and prescaler are frozen; the prescaler is cleared on the next `start`.
- `stop` in IDLE/HOLD is ignored.
- Priority when events coincide:
  - `stop` beats a same-cycle tick: no decrement.
  - `stop` beats a same-cycle `start`.
  - `rst_n` low beats everything.
- Reset mid-RUN returns all outputs to their reset values. `done` is not asserted.
- `load_valid` while RUN is not accepted and has no effect; the upstream holds it until `load_ready`.
- Arithmetic is unsigned. `count` never underflows, because RUN is never entered or kept with count = 0.
- The prescaler width is $clog2(`PRESCALE`), minimum 1 bit.

## Timing
- All outputs are registered, with no combinational input→output paths.
- Start latency: `start` sampled at edge k → `busy`=1 after edge k; first decrement at edge k+`PRESCALE`; decrement n at edge k+n·`PRESCALE`.
- Total run for loaded value V: `done` high during the cycle after edge k+V·`PRESCALE`. `busy` falls on that same edge.
- Load → count visible the cycle after the accepting edge.
- Resume after HOLD: the first decrement is `PRESCALE` cycles after the `start` edge.

## Configuration
- `FLIPFLOP_COUNTDOWN_AUTO_RELOAD_EN` defined:
  - At terminal count, `count`←`reload_reg` (not 0), `done` pulses, and the state stays RUN.
  - The prescaler keeps running, giving a periodic `done` every V·`PRESCALE` cycles until `stop` or reset.
  - `load_ready` stays 0 throughout.
- Undefined: one-shot behaviour as described in Operation.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `start`=1 and `load_valid`=1 → `count`=0, `reload_reg`=0, `busy`=0, `done`=0, `load_ready`=1.
- One-shot, `PRESCALE`=2: load 3, then `start` at edge 0 → `count` 2/1/0 after edges 2/4/6; `done`=1 only after edge 6; `busy` 1→0 at edge 6.
- Pause: load 4, start, `stop` at a tick edge → no decrement, `count`=4 (or current value) frozen for 10 cycles; `start` → next decrement `PRESCALE` cycles later; ends at 0 with one `done`.
- Handshake/corners:
  - `load_valid` with value 9 during RUN → ignored, `reload_reg` unchanged.
  - Load 0 + `start` in the same cycle → stays IDLE, `busy`=0.
  - Load 5 + `start` in the same cycle → RUN from 5.
  - `start`+`stop` in the same cycle → no RUN.
- Reset mid-run: load 0xF, start, drop `rst_n` at the 5th tick → all outputs at reset values after the edge, no `done`.
- With `FLIPFLOP_COUNTDOWN_AUTO_RELOAD_EN`, `PRESCALE`=1, load 2 → `count` sequence 2,1,2,1,…; `done` every 2 cycles; `stop` → HOLD at the current value.
